// File: rtl/code_conv_pkg.sv
// Shared types for the bit-serial binary/Gray converter.
// State encoding and mode constants used by the top and the bench.
package code_conv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } conv_state_e;

   localparam logic MODE_B2G = 1'b0;
   localparam logic MODE_G2B = 1'b1;

endpackage

// File: rtl/code_conv_serial_if.sv
// Word-level handshake bundle for the serial code converter.
// master = producer/consumer side, slave = converter side.
interface code_conv_serial_if #(
   parameter int WIDTH = 8
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_mode;

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_mode
   );

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_mode
   );

endinterface

// File: rtl/conv_bit_counter.sv
// Loadable down-counter selecting the result bit being resolved.
// Saturates at zero so it can never wrap.
module conv_bit_counter #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // next count: load wins over decrement, hold at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // count register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);

endmodule

// File: rtl/code_conv_serial.sv
// Bit-serial binary<->Gray converter, one result bit per clock.
// Word in on the input handshake, full word out on the output one.
module code_conv_serial
   import code_conv_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   code_conv_serial_if.slave    bus,
   output logic                 busy
);

   conv_state_e      state_q;
   conv_state_e      state_d;
   logic [WIDTH-1:0] src_q;
   logic [WIDTH-1:0] src_d;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] res_d;
   logic             mode_q;
   logic             mode_d;

   logic             cnt_load;
   logic             cnt_dec;
   logic [CNT_W-1:0] cnt;
   logic             cnt_zero;

   conv_bit_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (CNT_W'(WIDTH - 2)),
      .dec      (cnt_dec),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   // FSM next state, datapath capture and per-bit XOR select
   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      res_d    = res_q;
      mode_d   = mode_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               src_d            = bus.in_data;
               mode_d           = bus.in_mode;
               res_d            = '0;
               res_d[WIDTH-1]   = bus.in_data[WIDTH-1];
               cnt_load         = 1'b1;
               state_d          = CONV;
            end
         end
         CONV: begin
            for (int i = 0; i < WIDTH - 1; i++) begin
               if (cnt == CNT_W'(i)) begin
                  if (mode_q == MODE_G2B) begin
                     res_d[i] = res_q[i+1] ^ src_q[i];
                  end else begin
                     res_d[i] = src_q[i+1] ^ src_q[i];
                  end
               end
            end
            if (cnt_zero) begin
               state_d = DONE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         src_q   <= '0;
         res_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         res_q   <= res_d;
         mode_q  <= mode_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_data  = res_q;
   assign bus.out_mode  = mode_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_code_conv_serial.sv
// Directed and table-driven checks of code_conv_serial.
// Covers WIDTH 8, 2 and 16 with hand-computed expectations.
module tb_code_conv_serial;

   import code_conv_pkg::*;

   logic clk;
   logic rst_n;
   logic busy8;
   logic busy2;
   logic busy16;
   int   total;
   int   bad;
   int   cyc;

   code_conv_serial_if #(.WIDTH(8))  b8 ();
   code_conv_serial_if #(.WIDTH(2))  b2 ();
   code_conv_serial_if #(.WIDTH(16)) b16 ();

   code_conv_serial #(.WIDTH(8)) u8 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (b8),
      .busy  (busy8)
   );

   code_conv_serial #(.WIDTH(2)) u2 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (b2),
      .busy  (busy2)
   );

   code_conv_serial #(.WIDTH(16)) u16 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (b16),
      .busy  (busy16)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic       mode;
      logic [7:0] din;
      logic [7:0] dout;
   } vec8_t;

   vec8_t vecs [8];

   task automatic check(input string nm,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] b2g16(input logic [15:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [15:0] g2b16(input logic [15:0] g);
      logic [15:0] b;
      b = g;
      for (int s = 1; s < 16; s = s * 2) begin
         b = b ^ (b >> s);
      end
      return b;
   endfunction

   task automatic run8(input logic m, input logic [7:0] d,
                       input logic [7:0] e);
      int n;
      b8.in_data   = d;
      b8.in_mode   = m;
      b8.in_valid  = 1'b1;
      b8.out_ready = 1'b1;
      n = 0;
      while (!b8.in_ready && n < 20) begin
         tick();
         n++;
      end
      check("w8_ready_before", b8.in_ready, 1);
      tick();
      b8.in_valid = 1'b0;
      n = 0;
      while (!b8.out_valid && n < 40) begin
         tick();
         n++;
      end
      check("w8_latency", n, 7);
      check("w8_data", b8.out_data, e);
      check("w8_mode", b8.out_mode, m);
      tick();
      check("w8_ready_after", b8.in_ready, 1);
   endtask

   task automatic run2(input logic m, input logic [1:0] d,
                       input logic [1:0] e);
      int n;
      b2.in_data   = d;
      b2.in_mode   = m;
      b2.in_valid  = 1'b1;
      b2.out_ready = 1'b1;
      n = 0;
      while (!b2.in_ready && n < 20) begin
         tick();
         n++;
      end
      tick();
      b2.in_valid = 1'b0;
      n = 0;
      while (!b2.out_valid && n < 20) begin
         tick();
         n++;
      end
      check("w2_latency", n, 1);
      check("w2_data", b2.out_data, e);
      check("w2_mode", b2.out_mode, m);
      tick();
      check("w2_idle", busy2, 0);
   endtask

   localparam int NW = 24;
   logic [16:0] exp_q [$];

   initial begin
      int n;
      total = 0;
      bad   = 0;
      cyc   = 0;

      vecs[0] = '{MODE_B2G, 8'hB6, 8'hED};
      vecs[1] = '{MODE_G2B, 8'hED, 8'hB6};
      vecs[2] = '{MODE_G2B, 8'h80, 8'hFF};
      vecs[3] = '{MODE_G2B, 8'h00, 8'h00};
      vecs[4] = '{MODE_B2G, 8'h0F, 8'h08};
      vecs[5] = '{MODE_G2B, 8'hFF, 8'hAA};
      vecs[6] = '{MODE_B2G, 8'hAA, 8'hFF};
      vecs[7] = '{MODE_B2G, 8'h01, 8'h01};

      rst_n = 1'b0;
      b8.in_valid = 0;  b8.in_data = 0;  b8.in_mode = 0;
      b8.out_ready = 0;
      b2.in_valid = 0;  b2.in_data = 0;  b2.in_mode = 0;
      b2.out_ready = 0;
      b16.in_valid = 0; b16.in_data = 0; b16.in_mode = 0;
      b16.out_ready = 0;

      #12;
      check("rst_in_ready", b8.in_ready, 1);
      check("rst_out_valid", b8.out_valid, 0);
      check("rst_out_data", b8.out_data, 0);
      check("rst_out_mode", b8.out_mode, 0);
      check("rst_busy", busy8, 0);
      rst_n = 1'b1;
      tick();
      check("post_rst_ready", b8.in_ready, 1);

      for (int k = 0; k < 8; k++) begin
         run8(vecs[k].mode, vecs[k].din, vecs[k].dout);
      end

      // hold in DONE with out_ready low, stray in_valid ignored
      b8.out_ready = 1'b0;
      b8.in_data   = 8'hFF;
      b8.in_mode   = MODE_B2G;
      b8.in_valid  = 1'b1;
      tick();
      b8.in_valid = 1'b0;
      n = 0;
      while (!b8.out_valid && n < 40) begin
         tick();
         n++;
      end
      check("hold_latency", n, 7);
      for (int k = 0; k < 5; k++) begin
         b8.in_valid = (k == 1);
         b8.in_data  = 8'h12;
         b8.in_mode  = MODE_G2B;
         tick();
         check("hold_data", b8.out_data, 8'h80);
         check("hold_valid", b8.out_valid, 1);
         check("hold_in_ready", b8.in_ready, 0);
         check("hold_mode", b8.out_mode, MODE_B2G);
      end
      b8.in_valid  = 1'b1;
      b8.out_ready = 1'b1;
      tick();
      b8.in_valid = 1'b0;
      check("handoff_busy", busy8, 0);
      check("handoff_valid", b8.out_valid, 0);
      check("handoff_ready", b8.in_ready, 1);
      tick();
      check("handoff_no_accept", busy8, 0);

      // WIDTH=2 corner
      run2(MODE_B2G, 2'b11, 2'b10);
      run2(MODE_G2B, 2'b10, 2'b11);
      run2(MODE_G2B, 2'b01, 2'b01);

      // reset at CONV cycle 3 aborts the word
      b8.in_data   = 8'hB6;
      b8.in_mode   = MODE_B2G;
      b8.in_valid  = 1'b1;
      b8.out_ready = 1'b1;
      tick();
      b8.in_valid = 1'b0;
      tick();
      tick();
      tick();
      check("pre_abort_busy", busy8, 1);
      rst_n = 1'b0;
      #2;
      check("abort_valid", b8.out_valid, 0);
      check("abort_data", b8.out_data, 0);
      check("abort_ready", b8.in_ready, 1);
      check("abort_busy", busy8, 0);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) tick();
      check("abort_no_valid", b8.out_valid, 0);
      check("abort_idle", busy8, 0);
      run8(MODE_B2G, 8'h0F, 8'h08);

      // WIDTH=16 random stream with random backpressure
      fork
         begin : producer
            int last;
            int t;
            logic [15:0] d;
            logic m;
            last = 0;
            for (int w = 0; w < NW; w++) begin
               d = 16'($urandom);
               m = 1'($urandom % 2);
               b16.in_data  = d;
               b16.in_mode  = m;
               b16.in_valid = 1'b1;
               t = 0;
               while (!b16.in_ready && t < 400) begin
                  tick();
                  t++;
               end
               if (t >= 400) check("w16_accept_timeout", t, 0);
               tick();
               if (w > 0) check("w16_gap_ge17", (cyc - last) >= 17, 1);
               last = cyc;
               exp_q.push_back({m, d});
            end
            b16.in_valid = 1'b0;
         end
         begin : consumer
            int got;
            int guard;
            logic [16:0] e;
            logic [15:0] r;
            got = 0;
            guard = 0;
            while (got < NW && guard < 20000) begin
               b16.out_ready = 1'($urandom % 2);
               if (b16.out_valid && b16.out_ready) begin
                  if (exp_q.size() == 0) begin
                     check("w16_unexpected_word", 1, 0);
                  end else begin
                     e = exp_q.pop_front();
                     r = e[16] ? g2b16(e[15:0]) : b2g16(e[15:0]);
                     check("w16_data", b16.out_data, r);
                     check("w16_mode", b16.out_mode, e[16]);
                  end
                  got++;
               end
               tick();
               guard++;
            end
            check("w16_count", got, NW);
            b16.out_ready = 1'b1;
            for (int k = 0; k < 20; k++) tick();
            check("w16_no_dup", b16.out_valid, 0);
            check("w16_queue_empty", exp_q.size(), 0);
         end
      join

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
